// File: rtl/mem_access_unit.sv
// Memory-stage front end for a byte-addressed, word-wide data RAM: loads, stores, sub-word RMW stores.
// Optional MEM_ALIGN_CHECK_EN: misaligned halfword/word accesses abort with resp_err instead of being aligned down.
module mem_access_unit #(
  parameter int unsigned MEM_TOP = 63
) (
  input  logic        CLK,
  input  logic        nReset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR, ERR} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  state_t      state, state_nxt;
  logic [1:0]  r_off;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [15:0] r_wdata;

  logic [2:0]  nbytes;
  logic [32:0] end_addr;
  logic        illegal;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_data;
  logic [31:0] merged;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    nbytes   = 3'd4;
    illegal  = 1'b0;
    case (req_size)
      SZ_BYTE: nbytes = 3'd1;
      SZ_HALF: nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    // 33-bit sum so an address just below 2^32 cannot wrap into range.
    end_addr = {1'b0, req_addr} + {30'b0, nbytes} - 33'd1;
    if (req_size == SZ_BAD || end_addr > 33'(MEM_TOP)) illegal = 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
    if (req_size == SZ_HALF && req_addr[0])         illegal = 1'b1;
    if (req_size == SZ_WORD && req_addr[1:0] != 2'b00) illegal = 1'b1;
`endif
  end

  // RAM is big-endian: byte offset 0 is bits 31:24; halfword lane follows addr[1].
  always_comb begin
    byte_lane = mem_rdata[31:24];
    case (r_off)
      2'd0: byte_lane = mem_rdata[31:24];
      2'd1: byte_lane = mem_rdata[23:16];
      2'd2: byte_lane = mem_rdata[15:8];
      default: byte_lane = mem_rdata[7:0];
    endcase
    half_lane = r_off[1] ? mem_rdata[15:0] : mem_rdata[31:16];

    case (r_size)
      SZ_BYTE: load_data = {{24{r_signed & byte_lane[7]}}, byte_lane};
      SZ_HALF: load_data = {{16{r_signed & half_lane[15]}}, half_lane};
      default: load_data = mem_rdata;
    endcase

    merged = mem_rdata;
    if (r_size == SZ_BYTE) begin
      case (r_off)
        2'd0: merged[31:24] = r_wdata[7:0];
        2'd1: merged[23:16] = r_wdata[7:0];
        2'd2: merged[15:8]  = r_wdata[7:0];
        default: merged[7:0] = r_wdata[7:0];
      endcase
    end else if (r_off[1]) begin
      merged[15:0] = r_wdata;
    end else begin
      merged[31:16] = r_wdata;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (illegal)                    state_nxt = ERR;
          else if (!req_write)            state_nxt = LOAD;
          else if (req_size == SZ_WORD)   state_nxt = STORE;
          else                            state_nxt = RMW_RD;
        end
      end
      RMW_RD:  state_nxt = RMW_WR;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes decode straight from state so reset removes them without waiting for a clock.
  assign req_ready = (state == IDLE);
  assign busy      = ~req_ready;
  assign mem_read  = (state == LOAD)  || (state == RMW_RD);
  assign mem_write = (state == STORE) || (state == RMW_WR);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK or negedge nReset) begin
    if (!nReset) begin
      state      <= IDLE;
      r_off      <= 2'd0;
      r_size     <= SZ_BYTE;
      r_signed   <= 1'b0;
      r_wdata    <= 16'd0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
    end else begin
      state      <= state_nxt;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            r_off    <= req_addr[1:0];
            r_size   <= req_size;
            r_signed <= req_signed;
            r_wdata  <= req_wdata[15:0];
            if (!illegal) begin
              mem_addr <= {req_addr[31:2], 2'b00};
              if (req_write && req_size == SZ_WORD) mem_wdata <= req_wdata;
            end
          end
        end
        LOAD: begin
          resp_valid <= 1'b1;
          resp_rdata <= load_data;
        end
        RMW_RD: mem_wdata <= merged;
        ERR: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b1;
          resp_rdata <= 32'd0;
        end
        default: begin
          resp_valid <= 1'b1;
          resp_rdata <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: byte-array reference model, directed tests, then random traffic.
// Honours MEM_ALIGN_CHECK_EN the same way as the design.
module tb_mem_access_unit;

  logic        CLK = 1'b0;
  logic        nReset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, busy;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_unit #(.MEM_TOP(63)) dut (
    .CLK(CLK), .nReset(nReset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Data RAM: combinational big-endian read, full-word write on the falling edge.
  logic [7:0] ram [0:63];
  always_comb begin
    mem_rdata = 32'd0;
    if (mem_addr <= 32'd63)
      mem_rdata = {ram[{mem_addr[5:2], 2'b00}], ram[{mem_addr[5:2], 2'b01}],
                   ram[{mem_addr[5:2], 2'b10}], ram[{mem_addr[5:2], 2'b11}]};
  end
  always @(negedge CLK) begin
    if (mem_write && mem_addr <= 32'd63) begin
      ram[{mem_addr[5:2], 2'b00}] <= mem_wdata[31:24];
      ram[{mem_addr[5:2], 2'b01}] <= mem_wdata[23:16];
      ram[{mem_addr[5:2], 2'b10}] <= mem_wdata[15:8];
      ram[{mem_addr[5:2], 2'b11}] <= mem_wdata[7:0];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int unsigned due;
    int          lat;
    logic        err;
    logic [31:0] rdata;
    int          nrd;
    int          nwr;
    logic        st;
    int          ea;
    int          nb;
    logic [31:0] wdata;
    logic [31:0] waddr;
    logic [31:0] wword;
  } exp_t;

  logic [7:0] ref_mem [0:63];
  exp_t       expq[$];
  exp_t       cur;

  function automatic exp_t model_req(input logic w, input logic [1:0] sz, input logic sg,
                                     input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    logic [32:0] last;
    logic [31:0] v;
    logic [7:0]  wb [4];
    int wbase;
    e = '{default: 0};
    e.nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    last  = {1'b0, a} + 33'(e.nb) - 33'd1;
    e.err = (sz == 2'd3) || (last > 33'd63);
`ifdef MEM_ALIGN_CHECK_EN
    if (sz == 2'd1 && a[0])          e.err = 1'b1;
    if (sz == 2'd2 && a[1:0] != 2'd0) e.err = 1'b1;
`endif
    e.lat = 2;
    if (e.err) return e;
    e.ea    = (e.nb == 1) ? int'(a[5:0]) : (e.nb == 2) ? int'({a[5:1], 1'b0}) : int'({a[5:2], 2'b00});
    e.waddr = {a[31:2], 2'b00};
    e.st    = w;
    e.wdata = d;
    if (!w) begin
      e.nrd = 1;
      v = 32'd0;
      for (int i = 0; i < e.nb; i++) v = (v << 8) | 32'(ref_mem[e.ea + i]);
      if (sg && e.nb < 4 && v[8*e.nb-1]) v = v | ~((32'd1 << (8*e.nb)) - 32'd1);
      e.rdata = v;
    end else begin
      e.nwr = 1;
      e.nrd = (e.nb < 4) ? 1 : 0;
      e.lat = (e.nb < 4) ? 3 : 2;
      wbase = e.ea & ~3;
      for (int j = 0; j < 4; j++) wb[j] = ref_mem[wbase + j];
      for (int i = 0; i < e.nb; i++) wb[e.ea - wbase + i] = 8'(d >> (8*(e.nb-1-i)));
      e.wword = {wb[0], wb[1], wb[2], wb[3]};
    end
    return e;
  endfunction

  // Single compare process: every falling edge, outputs vs model.
  int unsigned cyc = 0;
  int rd_cnt = 0, wr_cnt = 0;
  always @(negedge CLK) begin
    logic exp_v;
    exp_t e;
    cyc++;
    if (!nReset) begin
      expq.delete();
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      check("busy_vs_ready", busy, !req_ready);
      check("strobe_exclusive", mem_read & mem_write, 1'b0);
      if (mem_read)  rd_cnt++;
      if (mem_write) wr_cnt++;
      if (mem_read || mem_write) check("mem_addr", mem_addr, cur.waddr);
      if (mem_write)             check("mem_wdata", mem_wdata, cur.wword);
      exp_v = (expq.size() > 0) && (expq[0].due == cyc);
      check("resp_valid", resp_valid, exp_v);
      if (exp_v) begin
        e = expq.pop_front();
        check("resp_err", resp_err, e.err);
        check("resp_rdata", resp_rdata, e.rdata);
        check("read_strobes", rd_cnt, e.nrd);
        check("write_strobes", wr_cnt, e.nwr);
        rd_cnt = 0;
        wr_cnt = 0;
        if (e.st && !e.err)
          for (int i = 0; i < e.nb; i++) ref_mem[e.ea + i] = 8'(e.wdata >> (8*(e.nb-1-i)));
      end
      if (req_valid && req_ready) begin
        e = model_req(req_write, req_size, req_signed, req_addr, req_wdata);
        e.due = cyc + e.lat;
        expq.push_back(e);
        cur = e;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er);
    logic got = 1'b0;
    rd = 32'hDEAD_BEEF;
    er = 1'bx;
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = d;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge CLK);
      if (req_ready) got = 1'b1;
    end
    check("accept_in_time", got, 1'b1);
    @(posedge CLK); #1;
    req_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge CLK);
      if (resp_valid) begin
        got = 1'b1;
        rd  = resp_rdata;
        er  = resp_err;
      end
    end
    check("response_in_time", got, 1'b1);
    @(posedge CLK); #1;
  endtask

  task automatic check_reset_vals();
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_err", resp_err, 1'b0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_read", mem_read, 1'b0);
    check("rst_mem_write", mem_write, 1'b0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic        got;
    int          gap;
    logic [1:0]  sz;
    logic [31:0] a;

    for (int i = 0; i < 64; i++) begin
      ram[i]     = 8'd0;
      ref_mem[i] = 8'd0;
    end
    nReset = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0;
    #2;
    check_reset_vals();
    #11 nReset = 1'b1;
    @(posedge CLK); #1;

    // Word store then load round trip.
    do_req(1'b1, 2'd2, 1'b0, 32'd8, 32'h1122_3344, rd, er);
    check("t1_store_err", er, 1'b0);
    do_req(1'b0, 2'd2, 1'b0, 32'd8, 32'd0, rd, er);
    check("t1_load", rd, 32'h1122_3344);
    check("t1_load_err", er, 1'b0);
    check("t1_ram_byte8", ram[8], 8'h11);

    // Byte store merges into the middle of the word.
    do_req(1'b1, 2'd0, 1'b0, 32'd10, 32'h0000_00AB, rd, er);
    check("t2_store_rdata", rd, 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'd8, 32'd0, rd, er);
    check("t2_load", rd, 32'h1122_AB44);

    // Extension.
    do_req(1'b0, 2'd0, 1'b1, 32'd10, 32'd0, rd, er);
    check("t3_byte_signed", rd, 32'hFFFF_FFAB);
    do_req(1'b0, 2'd0, 1'b0, 32'd10, 32'd0, rd, er);
    check("t3_byte_unsigned", rd, 32'h0000_00AB);
    do_req(1'b0, 2'd1, 1'b1, 32'd8, 32'd0, rd, er);
    check("t3_half_signed", rd, 32'h0000_1122);

    // Range and alignment errors.
    do_req(1'b0, 2'd2, 1'b0, 32'd62, 32'd0, rd, er);
    check("t4_range_err", er, 1'b1);
    check("t4_range_rdata", rd, 32'd0);
    do_req(1'b0, 2'd1, 1'b0, 32'd9, 32'd0, rd, er);
`ifdef MEM_ALIGN_CHECK_EN
    check("t4_half_misaligned_err", er, 1'b1);
`else
    check("t4_half_misaligned_err", er, 1'b0);
    check("t4_half_misaligned_data", rd, 32'h0000_1122);
`endif
    do_req(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'd0, rd, er);
    check("t4_wrap_err", er, 1'b1);
    do_req(1'b0, 2'd3, 1'b0, 32'd0, 32'd0, rd, er);
    check("t4_size3_err", er, 1'b1);

    // Reset during RMW_RD drops the store.
    do_req(1'b1, 2'd2, 1'b0, 32'd4, 32'hCAFE_F00D, rd, er);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_addr = 32'd4; req_wdata = 32'h55;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge CLK);
      if (req_ready) got = 1'b1;
    end
    check("t5_accept", got, 1'b1);
    @(posedge CLK); #1;
    req_valid = 1'b0;
    check("t5_in_rmw_rd", mem_read, 1'b1);
    nReset = 1'b0;
    #1;
    check_reset_vals();
    repeat (2) @(posedge CLK);
    #3 nReset = 1'b1;
    @(posedge CLK); #1;
    check("t5_ram_word4", {ram[4], ram[5], ram[6], ram[7]}, 32'hCAFE_F00D);
    check("t5_ready_after", req_ready, 1'b1);

    // Back-to-back word loads with req_valid held.
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req_addr = 32'(4 * k);
      gap = 0;
      got = 1'b0;
      while (!got && gap < 20) begin
        @(negedge CLK);
        gap++;
        if (req_ready) got = 1'b1;
      end
      check("t6_accept", got, 1'b1);
      if (k > 0) check("t6_gap", gap, 2);
      @(posedge CLK); #1;
    end
    req_valid = 1'b0;
    repeat (4) @(posedge CLK);
    #1;

    // Random traffic against the model.
    for (int n = 0; n < 150; n++) begin
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                       : 32'($urandom_range(0, 70));
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, rd, er);
      repeat ($urandom_range(0, 2)) @(posedge CLK);
      #1;
    end
    repeat (4) @(posedge CLK);
    #1;
    check("queue_drained", expq.size(), 0);
    for (int i = 0; i < 64; i++) check("final_ram", ram[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
